// File: rtl/const_tune_ctrl.sv
// Front-panel sequencer: synchronizes four buttons into rail/parameter
// selection and single-cycle inc/dec strobes with hold-to-repeat.
module const_tune_ctrl #(
    parameter int NUM_RAILS     = 5,
    parameter int NUM_PARAMS    = 3,
    parameter int HOLD_CYCLES   = 2000000,
    parameter int REPEAT_CYCLES = 200000,
    parameter int CNT_WIDTH     = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_up,
    input  logic       i_btn_dn,
    input  logic       i_btn_param,
    input  logic       i_btn_rail,
    output logic [3:0] o_choose_c,
    output logic [3:0] o_choose,
    output logic       o_inc_const,
    output logic       o_dec_const,
    output logic       o_active
);

    localparam int B_UP    = 0;
    localparam int B_DN    = 1;
    localparam int B_PARAM = 2;
    localparam int B_RAIL  = 3;

    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] REP_LOAD  = CNT_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    localparam logic [3:0] RAIL_LAST  = 4'(NUM_RAILS - 1);
    localparam logic [3:0] PARAM_LAST = 4'(NUM_PARAMS - 1);

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [3:0] w_btn;
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_prev;
    logic [3:0] r_rise;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_dir;
    logic                 w_dir_nxt;
    logic                 r_inc;
    logic                 w_inc_nxt;
    logic                 r_dec;
    logic                 w_dec_nxt;

    logic [3:0] r_choose_c;
    logic [3:0] w_choose_c_nxt;
    logic [3:0] r_choose;
    logic [3:0] w_choose_nxt;

    logic w_up_lvl;
    logic w_dn_lvl;
    logic w_held;
    logic w_both;

    assign w_btn = {i_btn_rail, i_btn_param, i_btn_dn, i_btn_up};

    // Two-flop synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_rise  <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_rise  <= r_sync2 & ~r_prev;
        end
    end

    assign w_up_lvl = r_sync2[B_UP];
    assign w_dn_lvl = r_sync2[B_DN];
    assign w_both   = w_up_lvl & w_dn_lvl;
    assign w_held   = (r_dir == DIR_DN) ? w_dn_lvl : w_up_lvl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dir      <= DIR_UP;
            r_inc      <= 1'b0;
            r_dec      <= 1'b0;
            r_choose_c <= '0;
            r_choose   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dir      <= w_dir_nxt;
            r_inc      <= w_inc_nxt;
            r_dec      <= w_dec_nxt;
            r_choose_c <= w_choose_c_nxt;
            r_choose   <= w_choose_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_inc_nxt   = 1'b0;
        w_dec_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_rise[B_UP] && !r_rise[B_DN]) begin
                    w_inc_nxt   = 1'b1;
                    w_dir_nxt   = DIR_UP;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_state_nxt = S_HOLD;
                end else if (r_rise[B_DN] && !r_rise[B_UP]) begin
                    w_dec_nxt   = 1'b1;
                    w_dir_nxt   = DIR_DN;
                    w_cnt_nxt   = HOLD_LOAD;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (!w_held || w_both) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_ZERO) begin
                    w_inc_nxt   = (r_dir == DIR_UP);
                    w_dec_nxt   = (r_dir == DIR_DN);
                    w_cnt_nxt   = REP_LOAD;
                    w_state_nxt = S_REPEAT;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Rail wins over param; selection presses outside IDLE are dropped.
    always_comb begin
        w_choose_c_nxt = r_choose_c;
        w_choose_nxt   = r_choose;
        if (r_state == S_IDLE) begin
            if (r_rise[B_RAIL]) begin
                w_choose_c_nxt = (r_choose_c >= RAIL_LAST) ? 4'd0
                               : r_choose_c + 4'd1;
                w_choose_nxt   = 4'd0;
            end else if (r_rise[B_PARAM]) begin
                w_choose_nxt = (r_choose >= PARAM_LAST) ? 4'd0
                             : r_choose + 4'd1;
            end
        end
    end

    assign o_choose_c  = r_choose_c;
    assign o_choose    = r_choose;
    assign o_inc_const = r_inc;
    assign o_dec_const = r_dec;
    assign o_active    = (r_state != S_IDLE);

endmodule
